// File: rtl/sdram_responder.sv
// sdram_responder
// Target-side end of the arbitrated SDRAM request bus. It runs the SDRAM
// power-up sequence, periodic auto-refresh, and single-word READ/WRITE
// accesses with auto-precharge. Each access returns a one-cycle ack.
//
// Ports
//   clk0, reset_n           clock (rising edge), async active-low reset
//   sdram_addr[23:0]        word address {bank[23:22], row[21:10], col[9:0]}
//   sdram_cmd[2:0]          000 NOP, 001 READ, 010 WRITE, other codes = NOP
//   sdram_datain[31:0]      write data
//   sdram_dataout[31:0]     last read word (held)
//   sdram_ack               one-cycle pulse when an access completes
//   sdram_busy              high whenever the engine is not in IDLE
//   sdr_cs_n/ras_n/cas_n/we_n, sdr_ba, sdr_a, sdr_dqm   SDRAM pins (registered)
//   sdr_dq_out, sdr_dq_oe, sdr_dq_in                    split data bus
module sdram_responder #(
    parameter int T_RCD        = 2,
    parameter int CAS_LAT      = 2,
    parameter int T_RP         = 2,
    parameter int T_WR         = 2,
    parameter int T_RFC        = 7,
    parameter int REF_INTERVAL = 390,
    parameter int INIT_WAIT    = 100
) (
    input  logic        clk0,
    input  logic        reset_n,
    input  logic [23:0] sdram_addr,
    input  logic [2:0]  sdram_cmd,
    input  logic [31:0] sdram_datain,
    output logic [31:0] sdram_dataout,
    output logic        sdram_ack,
    output logic        sdram_busy,
    output logic        sdr_cs_n,
    output logic        sdr_ras_n,
    output logic        sdr_cas_n,
    output logic        sdr_we_n,
    output logic [1:0]  sdr_ba,
    output logic [11:0] sdr_a,
    output logic        sdr_dqm,
    output logic [31:0] sdr_dq_out,
    output logic        sdr_dq_oe,
    input  logic [31:0] sdr_dq_in
);

    localparam int CNT_W = 16;
    localparam int REF_W = $clog2(REF_INTERVAL + 1);

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;

    // Burst length 1, sequential, CAS latency from the parameter.
    localparam logic [11:0] MODE_REG = {2'b00, 1'b0, 2'b00, 3'(CAS_LAT), 1'b0, 3'b000};

    typedef enum logic [3:0] {
        ST_INIT_WAIT, ST_INIT_PRE, ST_INIT_REF1, ST_INIT_REF2, ST_INIT_MRS,
        ST_IDLE, ST_REFRESH, ST_ACTIVE, ST_ACCESS, ST_ACK, ST_RELEASE
    } state_t;

    typedef struct packed {
        logic        wr;
        logic [9:0]  col;
        logic [31:0] data;
    } req_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [REF_W-1:0]   ref_cnt;
    logic               ref_pending;
    logic               init_done;
    logic [3:0]         pin_cmd;
    req_t               req;
    logic [CAS_LAT:0]   vld_pipe;   // bit k set = k cycles after the READ cycle
    logic               is_rw;

    assign is_rw = (sdram_cmd == 3'b001) || (sdram_cmd == 3'b010);
    assign {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = pin_cmd;

    always_ff @(posedge clk0 or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_INIT_WAIT;
            cnt           <= CNT_W'(INIT_WAIT - 1);
            ref_cnt       <= REF_W'(REF_INTERVAL);
            ref_pending   <= 1'b0;
            init_done     <= 1'b0;
            pin_cmd       <= CMD_NOP;
            req           <= '0;
            vld_pipe      <= '0;
            sdr_ba        <= '0;
            sdr_a         <= '0;
            sdr_dqm       <= 1'b1;
            sdr_dq_out    <= '0;
            sdr_dq_oe     <= 1'b0;
            sdram_dataout <= '0;
            sdram_ack     <= 1'b0;
            sdram_busy    <= 1'b1;
        end else begin
            // Pin commands and strobes are single-cycle unless re-issued.
            pin_cmd   <= CMD_NOP;
            sdr_dq_oe <= 1'b0;
            sdram_ack <= 1'b0;
            vld_pipe  <= {vld_pipe[CAS_LAT-1:0], 1'b0};
            if (vld_pipe[CAS_LAT])
                sdram_dataout <= sdr_dq_in;

            case (state)
                ST_IDLE: begin
                    if (ref_pending) begin
                        pin_cmd     <= CMD_REF;
                        ref_pending <= 1'b0;
                        cnt         <= CNT_W'(T_RFC - 1);
                        state       <= ST_REFRESH;
                        sdram_busy  <= 1'b1;
                    end else if (is_rw) begin
                        req        <= '{wr: sdram_cmd[1], col: sdram_addr[9:0], data: sdram_datain};
                        pin_cmd    <= CMD_ACT;
                        sdr_ba     <= sdram_addr[23:22];
                        sdr_a      <= sdram_addr[21:10];
                        cnt        <= CNT_W'(T_RCD - 1);
                        state      <= ST_ACTIVE;
                        sdram_busy <= 1'b1;
                    end
                end
                ST_ACK: state <= ST_RELEASE;
                // Hold here while the grant persists so the same request is
                // not executed twice.
                ST_RELEASE: begin
                    if (!is_rw) begin
                        state      <= ST_IDLE;
                        sdram_busy <= 1'b0;
                    end
                end
                // Timed states: the command was issued on entry; cnt holds
                // the remaining wait cycles minus one.
                default: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        case (state)
                            ST_INIT_WAIT: begin
                                sdr_dqm <= 1'b0;
                                pin_cmd <= CMD_PRE;
                                sdr_a   <= 12'h400;     // a[10]: all banks
                                cnt     <= CNT_W'(T_RP - 1);
                                state   <= ST_INIT_PRE;
                            end
                            ST_INIT_PRE: begin
                                pin_cmd <= CMD_REF;
                                cnt     <= CNT_W'(T_RFC - 1);
                                state   <= ST_INIT_REF1;
                            end
                            ST_INIT_REF1: begin
                                pin_cmd <= CMD_REF;
                                cnt     <= CNT_W'(T_RFC - 1);
                                state   <= ST_INIT_REF2;
                            end
                            ST_INIT_REF2: begin
                                pin_cmd <= CMD_MRS;
                                sdr_ba  <= 2'b00;
                                sdr_a   <= MODE_REG;
                                cnt     <= CNT_W'(1);   // two NOPs after MRS
                                state   <= ST_INIT_MRS;
                            end
                            ST_INIT_MRS: begin
                                init_done  <= 1'b1;
                                state      <= ST_IDLE;
                                sdram_busy <= 1'b0;
                            end
                            ST_REFRESH: begin
                                state      <= ST_IDLE;
                                sdram_busy <= 1'b0;
                            end
                            ST_ACTIVE: begin
                                sdr_a <= {1'b0, 1'b1, req.col};  // a[10]: auto-precharge
                                if (req.wr) begin
                                    pin_cmd    <= CMD_WR;
                                    sdr_dq_out <= req.data;
                                    sdr_dq_oe  <= 1'b1;
                                    cnt        <= CNT_W'(T_WR + T_RP);
                                end else begin
                                    pin_cmd     <= CMD_RD;
                                    vld_pipe[0] <= 1'b1;
                                    cnt         <= CNT_W'(CAS_LAT + T_RP);
                                end
                                state <= ST_ACCESS;
                            end
                            ST_ACCESS: begin
                                sdram_ack <= 1'b1;
                                state     <= ST_ACK;
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
            endcase

            // Refresh timer runs after init; placed last so a new expiry
            // wins over a same-cycle clear.
            if (init_done) begin
                if (ref_cnt == '0) begin
                    ref_cnt     <= REF_W'(REF_INTERVAL);
                    ref_pending <= 1'b1;
                end else begin
                    ref_cnt <= ref_cnt - REF_W'(1);
                end
            end
        end
    end

endmodule
